cache_dm_controller: RTL and testbench

Sequencing controller for the direct-mapped cache datapath. It accepts one processor request at a time on a start/done handshake, holds the tag/valid/dirty store, performs hit lookup, and runs dirty-line write-back and line refill against main memory over a request/acknowledge handshake. It sits between the requester and two blocks: the 64-line × 128-bit cache data array and the main memory port.

---
 rtl/cache_dm_controller.sv | 237 +++++++++++++++++++++++
 tb/tb_cache_dm_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_dm_controller.sv
// Direct-mapped cache sequencing controller: owns the tag/valid/dirty store,
// resolves hits, and runs write-back and refill against main memory.
// Optional build macro CACHE_STATS_EN adds saturating hit/miss counters.
module cache_dm_controller #(
    parameter int ADDR_W  = 15,
    parameter int INDEX_W = 6,
    parameter int LINE_W  = 128
) (
    input  logic                globalclock,
    input  logic                reset,
    input  logic                start,
    input  logic                wrEn,
    input  logic [ADDR_W-1:0]   address,
    input  logic [31:0]         wrData,
    output logic                busy,
    output logic                done,
    output logic                hit,
    output logic [31:0]         outData_cache,
    output logic [INDEX_W-1:0]  ca_index,
    input  logic [LINE_W-1:0]   ca_rline,
    output logic                ca_we,
    output logic [LINE_W-1:0]   ca_wline,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-3:0]   mem_addr,
    output logic [LINE_W-1:0]   mem_wdata,
    input  logic [LINE_W-1:0]   memOut,
    input  logic                mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]         hit_cnt,
    output logic [15:0]         miss_cnt
`endif
);
    localparam int TAG_W = ADDR_W - INDEX_W - 2;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 wr_q, wr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 hit_q, hit_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_W-3:0]    mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic [LINES-1:0]     valid_q, valid_d;
    logic [LINES-1:0]     dirty_q, dirty_d;
    logic [TAG_W-1:0]     tag_mem [LINES];
    logic                 tag_we;

    logic [TAG_W-1:0]     req_tag;
    logic [INDEX_W-1:0]   req_idx;
    logic [1:0]           req_off;
    logic                 lookup_hit;

    assign req_tag    = addr_q[ADDR_W-1 -: TAG_W];
    assign req_idx    = addr_q[INDEX_W+1:2];
    assign req_off    = addr_q[1:0];
    assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    // Replace one 32-bit word of a line.
    function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                     input logic [1:0] off,
                                                     input logic [31:0] w);
        logic [LINE_W-1:0] r;
        r = line;
        r[{off, 5'b00000} +: 32] = w;
        return r;
    endfunction

    // Next-state, store updates and data-array/memory controls.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        hit_d       = hit_q;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        tag_we      = 1'b0;
        ca_we       = 1'b0;
        ca_wline    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = address;
                    wr_d    = wrEn;
                    wdata_d = wrData;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                hit_d = lookup_hit;
                if (lookup_hit) begin
                    if (wr_q) begin
                        ca_we            = 1'b1;
                        ca_wline         = merge_word(ca_rline, req_off, wdata_q);
                        dirty_d[req_idx] = 1'b1;
                    end else begin
                        rdata_d = ca_rline[{req_off, 5'b00000} +: 32];
                    end
                    state_d = S_DONE;
                end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
                    // Victim line is still on ca_rline; snapshot it so the
                    // write-back payload stays stable until acknowledged.
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {tag_mem[req_idx], req_idx};
                    mem_wdata_d = ca_rline;
                    state_d     = S_WRITEBACK;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {req_tag, req_idx};
                    state_d    = S_REFILL;
                end
            end
            S_WRITEBACK: begin
                if (mem_req_q && mem_ack) begin
                    // Request drops here and re-rises one cycle later in
                    // REFILL, so memory always sees a gap between the two.
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {req_tag, req_idx};
                    state_d    = S_REFILL;
                end
            end
            S_REFILL: begin
                if (!mem_req_q) begin
                    mem_req_d = 1'b1;
                end else if (mem_ack) begin
                    mem_req_d        = 1'b0;
                    ca_we            = 1'b1;
                    ca_wline         = wr_q ? merge_word(memOut, req_off, wdata_q) : memOut;
                    tag_we           = 1'b1;
                    valid_d[req_idx] = 1'b1;
                    dirty_d[req_idx] = wr_q;
                    if (!wr_q) rdata_d = memOut[{req_off, 5'b00000} +: 32];
                    state_d          = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and bookkeeping registers; reset abandons any memory transaction.
    always_ff @(posedge globalclock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            hit_q       <= 1'b0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            hit_q       <= hit_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
        end
    end

    // Tag store; contents are meaningless while the valid bit is clear.
    always_ff @(posedge globalclock) begin
        if (tag_we) tag_mem[req_idx] <= req_tag;
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign hit           = (state_q == S_DONE) && hit_q;
    assign outData_cache = rdata_q;
    assign ca_index      = req_idx;
    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;

`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    // Saturating hit/miss counts, bumped once per completed request.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == S_DONE) begin
            if (hit_q) begin
                if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
            end else begin
                if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge globalclock or posedge reset) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_dm_controller.sv
// Directed bench for cache_dm_controller: behavioural data array and
// main-memory responder, table of request vectors, then corner sequences.
module tb_cache_dm_controller;
    logic         globalclock;
    logic         reset;
    logic         start;
    logic         wrEn;
    logic [14:0]  address;
    logic [31:0]  wrData;
    logic         busy, done, hit;
    logic [31:0]  outData_cache;
    logic [5:0]   ca_index;
    logic [127:0] ca_rline;
    logic         ca_we;
    logic [127:0] ca_wline;
    logic         mem_req, mem_we;
    logic [12:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] memOut = '0;
    logic         mem_ack = 1'b0;
`ifdef CACHE_STATS_EN
    logic [15:0]  hit_cnt, miss_cnt;
`endif

    cache_dm_controller dut (
        .globalclock(globalclock), .reset(reset), .start(start), .wrEn(wrEn),
        .address(address), .wrData(wrData), .busy(busy), .done(done), .hit(hit),
        .outData_cache(outData_cache), .ca_index(ca_index), .ca_rline(ca_rline),
        .ca_we(ca_we), .ca_wline(ca_wline), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .memOut(memOut), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    initial begin
        globalclock = 1'b0;
        forever #5 globalclock = ~globalclock;
    end

    // Cache data array model.
    logic [127:0] data_arr [64];
    always @(posedge globalclock) if (ca_we) data_arr[ca_index] <= ca_wline;
    assign ca_rline = data_arr[ca_index];

    // Main memory responder: acks after mem_lat cycles of mem_req.
    logic [127:0] mem [8192];
    bit           mem_init = 1'b0;
    int           mem_lat = 3;
    int           lat_cnt = 0;
    int           n_acks = 0;
    int           gap_err = 0;
    logic [12:0]  wb_addr = '0, rf_addr = '0;
    logic [127:0] wb_data = '0;
    always @(negedge globalclock) begin
        if (!mem_init) begin
            mem[13'h1E0C] = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
            mem[13'h000C] = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
            mem[13'h0441] = 128'h8888_8888_7777_7777_6666_6666_5555_5555;
            mem[13'h0001] = '0;
            mem[13'h0010] = '0;
            mem[13'h0008] = '0;
            mem_init = 1'b1;
        end
        if (mem_ack) begin
            if (mem_req) gap_err++;
            mem_ack = 1'b0;
            lat_cnt = 0;
        end else if (reset || !mem_req) begin
            lat_cnt = 0;
        end else begin
            lat_cnt++;
            if (lat_cnt >= mem_lat) begin
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    wb_addr = mem_addr;
                    wb_data = mem_wdata;
                end else begin
                    memOut  = mem[mem_addr];
                    rf_addr = mem_addr;
                end
                mem_ack = 1'b1;
                n_acks++;
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one request; returns edges from the accepting edge to done (-1 on timeout).
    task automatic run_req(input logic w, input logic [14:0] a, input logic [31:0] d,
                           output int cyc);
        @(negedge globalclock);
        start = 1'b1; wrEn = w; address = a; wrData = d;
        @(posedge globalclock);
        @(negedge globalclock);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 60) begin
            @(negedge globalclock);
            cyc++;
        end
        if (!done) cyc = -1;
    endtask

    typedef struct {
        logic         wr;
        logic [14:0]  addr;
        logic [31:0]  wdata;
        logic         exp_hit;
        logic [31:0]  exp_rdata;
        int           exp_cyc;
        int           exp_acks;
        logic         exp_wb;
        logic [12:0]  exp_wb_addr;
        logic [127:0] exp_wb_data;
        logic [12:0]  exp_rf_addr;
    } vec_t;

    vec_t vt [10];

    initial begin
        int cyc, acks0, k, ndone, first, second;
        vt[0] = '{1'b0, 15'h7833, 32'h0,         1'b0, 32'hDDDD_DDDD, 5, 1, 1'b0, 13'h0, 128'h0, 13'h1E0C};
        vt[1] = '{1'b0, 15'h7831, 32'h0,         1'b1, 32'hBBBB_BBBB, 2, 0, 1'b0, 13'h0, 128'h0, 13'h0};
        vt[2] = '{1'b1, 15'h7830, 32'h1234_5678, 1'b1, 32'h0,         2, 0, 1'b0, 13'h0, 128'h0, 13'h0};
        vt[3] = '{1'b0, 15'h7830, 32'h0,         1'b1, 32'h1234_5678, 2, 0, 1'b0, 13'h0, 128'h0, 13'h0};
        vt[4] = '{1'b0, 15'h0030, 32'h0,         1'b0, 32'h1111_1111, 9, 2, 1'b1, 13'h1E0C,
                  128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_1234_5678, 13'h000C};
        vt[5] = '{1'b0, 15'h7832, 32'h0,         1'b0, 32'hCCCC_CCCC, 5, 1, 1'b0, 13'h0, 128'h0, 13'h1E0C};
        vt[6] = '{1'b1, 15'h0005, 32'hAAAA_0001, 1'b0, 32'h0,         5, 1, 1'b0, 13'h0, 128'h0, 13'h0001};
        vt[7] = '{1'b0, 15'h0005, 32'h0,         1'b1, 32'hAAAA_0001, 2, 0, 1'b0, 13'h0, 128'h0, 13'h0};
        vt[8] = '{1'b0, 15'h1105, 32'h0,         1'b0, 32'h6666_6666, 9, 2, 1'b1, 13'h0001,
                  128'h0000_0000_0000_0000_AAAA_0001_0000_0000, 13'h0441};
        vt[9] = '{1'b0, 15'h0005, 32'h0,         1'b0, 32'hAAAA_0001, 5, 1, 1'b0, 13'h0, 128'h0, 13'h0001};

        reset = 1'b1; start = 1'b0; wrEn = 1'b0; address = '0; wrData = '0;
        repeat (3) @(negedge globalclock);
        reset = 1'b0;
        @(negedge globalclock);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_hit", hit, 1'b0);
        chk("rst_outdata", outData_cache, 32'h0);
        chk("rst_ca_we", ca_we, 1'b0);
        chk("rst_ca_wline", ca_wline, 128'h0);
        chk("rst_ca_index", ca_index, 6'h0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 13'h0);
        chk("rst_mem_wdata", mem_wdata, 128'h0);

        for (int i = 0; i < 10; i++) begin
            acks0 = n_acks;
            run_req(vt[i].wr, vt[i].addr, vt[i].wdata, cyc);
            chk($sformatf("v%0d_hit", i), hit, vt[i].exp_hit);
            chk($sformatf("v%0d_latency", i), cyc, vt[i].exp_cyc);
            if (!vt[i].wr) chk($sformatf("v%0d_rdata", i), outData_cache, vt[i].exp_rdata);
            chk($sformatf("v%0d_mem_txns", i), n_acks - acks0, vt[i].exp_acks);
            if (vt[i].exp_wb) begin
                chk($sformatf("v%0d_wb_addr", i), wb_addr, vt[i].exp_wb_addr);
                chk($sformatf("v%0d_wb_data", i), wb_data, vt[i].exp_wb_data);
            end
            if (vt[i].exp_acks > 0) chk($sformatf("v%0d_rf_addr", i), rf_addr, vt[i].exp_rf_addr);
        end

        // Reset while a refill is outstanding.
        mem_lat = 40;
        @(negedge globalclock);
        start = 1'b1; wrEn = 1'b0; address = 15'h0020;
        @(negedge globalclock);
        start = 1'b0;
        k = 0;
        while (!mem_req && k < 20) begin @(negedge globalclock); k++; end
        chk("midrst_req_seen", mem_req, 1'b1);
        reset = 1'b1;
        #1;
        chk("midrst_mem_req", mem_req, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_mem_addr", mem_addr, 13'h0);
        @(negedge globalclock);
        reset = 1'b0;
        mem_lat = 3;
        run_req(1'b0, 15'h7833, 32'h0, cyc);
        chk("postrst_hit", hit, 1'b0);
        chk("postrst_latency", cyc, 5);
        chk("postrst_rdata", outData_cache, 32'hDDDD_DDDD);

        // start toggled while busy must not spawn extra requests.
        @(negedge globalclock);
        start = 1'b1; wrEn = 1'b0; address = 15'h0040;
        @(posedge globalclock);
        @(negedge globalclock);
        wrEn = 1'b1; address = 15'h7833; wrData = 32'hDEAD_BEEF;
        ndone = 0;
        for (int i = 0; i < 14; i++) begin
            if (i == 3) start = 1'b0;
            if (done) ndone++;
            @(negedge globalclock);
        end
        chk("busy_start_dones", ndone, 1);
        run_req(1'b0, 15'h7833, 32'h0, cyc);
        chk("busy_start_no_write_hit", hit, 1'b1);
        chk("busy_start_no_write_data", outData_cache, 32'hDDDD_DDDD);

        // start held high: second request accepted right after done.
        @(negedge globalclock);
        start = 1'b1; wrEn = 1'b0; address = 15'h7831;
        @(posedge globalclock);
        first = -1; second = -1;
        for (int i = 1; i <= 20 && second < 0; i++) begin
            @(negedge globalclock);
            if (done) begin
                if (first < 0) first = i;
                else begin second = i; start = 1'b0; end
            end
        end
        start = 1'b0;
        chk("b2b_first_done", first, 2);
        chk("b2b_spacing", second - first, 3);
        chk("b2b_hit", hit, 1'b1);
        chk("b2b_rdata", outData_cache, 32'hBBBB_BBBB);

        chk("req_gap_between_txns", gap_err, 0);

`ifdef CACHE_STATS_EN
        @(negedge globalclock);
        reset = 1'b1;
        @(negedge globalclock);
        reset = 1'b0;
        chk("stats_rst_hit", hit_cnt, 16'h0);
        chk("stats_rst_miss", miss_cnt, 16'h0);
        run_req(1'b0, 15'h7833, 32'h0, cyc);
        run_req(1'b0, 15'h7833, 32'h0, cyc);
        run_req(1'b0, 15'h0030, 32'h0, cyc);
        @(negedge globalclock);
        chk("stats_hit_cnt", hit_cnt, 16'd1);
        chk("stats_miss_cnt", miss_cnt, 16'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
